reg_file: RTL and testbench
===========================

# reg_file

Architectural register file feeding the ALU's `a`/`b` operands and accepting the ALU result back as the write-back value. It has two combinational read ports and one clocked write port, with optional same-cycle write-to-read bypass. It also contains overflow-trap logic: a signed add/sub whose ALU `of` flag is set does not commit its result. Instead, the block captures the result in a trap holding register that the control unit acknowledges with a handshake.

## Interface
Parameters:
- DW, 32, data width (matches ALU operand width)
- AW, 5, register address width; 2**AW registers
- BYPASS, 1, 1 = forward same-cycle committed write data to read ports; 0 = reads see array only

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ra1  in  AW  read address, port 1 (ALU operand a)
- ra2  in  AW  read address, port 2 (ALU operand b)
- rd1  out  DW  read data, port 1
- rd2  out  DW  read data, port 2
- we  in  1  write request
- wa  in  AW  write address
- wd  in  DW  write data (ALU out)
- ovf_chk  in  1  current write comes from a trapping signed add/sub
- ovf  in  1  ALU overflow flag for current write
- trap_valid  out  1  a suppressed-overflow write is pending
- trap_rd  out  AW  destination of captured faulting write
- trap_data  out  DW  wrapped result of captured faulting write
- trap_ack  in  1  control unit consumes pending trap
- trap_count  out  8  saturating count of suppressed writes since reset

## Operation
- Register 0 is hardwired to 0: reads of address 0 return 0, and writes to it never alter state.
- Commit condition: `commit = we & ~(ovf_chk & ovf) & (wa != 0)`.
- Suppress condition: `suppress = we & ovf_chk & ovf`.
  - Suppression applies for any `wa`, including 0.
  - The array is never written when `suppress` is true.
- Reads are combinational: `rdN = (BYPASS & commit & wa == raN) ? wd : regs[raN]`, forced to 0 when `raN == 0`.
- The bypass never forwards a suppressed write.
- Trap register FSM has two states:
  - IDLE (`trap_valid = 0`):
    - On `suppress`: capture `wa` into `trap_rd` and `wd` into `trap_data`, then go to PEND.
  - PEND (`trap_valid = 1`):
    - On `trap_ack` with no `suppress`: go to IDLE. `trap_rd`/`trap_data` hold their last values.
    - On `trap_ack` with `suppress`: recapture the new `wa`/`wd` and stay in PEND.
    - On `suppress` with no `trap_ack`: keep the first fault; the new fault is not captured.
    - Otherwise: hold.
- `trap_ack` in IDLE is ignored.
- `trap_count` increments by 1 on every `suppress` cycle in either state and saturates at 255.
- Arithmetic is unsigned modulo for addresses; no width extension is performed on `wd`.

## Timing
- Read latency is 0 cycles (combinational from `ra*`, array state, and bypass inputs).
- Array write, trap capture, FSM transition, and `trap_count` update all take effect at the rising `clk` edge where the condition is sampled.
  - They are visible on outputs immediately after that edge.
- `trap_valid` rises the cycle after the faulting write and falls the cycle after the accepted `trap_ack`.
- Reset value of every state element and output, while `rst` = 1:
  - All registers are 0.
  - `trap_valid` = 0, `trap_rd` = 0, `trap_data` = 0, `trap_count` = 0.
  - `rd1` and `rd2` read 0.
  - The bypass is disabled while `rst` is high.
- Reset asserted mid-operation clears state immediately and asynchronously.
  - A pending trap is discarded.
  - A write sampled at the same edge as reset is lost.
- Reset deassertion is synchronised by the integrating top level; the block assumes it is clean relative to `clk`.

## Test plan
- Reset then read: assert `rst`, read all 32 addresses on both ports -> every `rd1`/`rd2` = 0x00000000, `trap_valid` = 0, `trap_count` = 0.
- Basic write/read and r0:
  - Write 0xDEADBEEF to r5, then read `ra1` = 5 next cycle -> `rd1` = 0xDEADBEEF.
  - Write 0x12345678 to r0 -> `rd2` at `ra2` = 0 stays 0.
- Bypass, with BYPASS = 1: `we` = 1, `wa` = 7, `wd` = 0xA5A5A5A5, `ra1` = `ra2` = 7 in the same cycle -> both read 0xA5A5A5A5 before the edge.
  - With BYPASS = 0, the same stimulus returns the old r7 value.
- Overflow suppression:
  - r3 = 0x11111111, then `we` = 1, `wa` = 3, `wd` = 0x80000000, `ovf_chk` = 1, `ovf` = 1.
  - Expected: r3 stays 0x11111111, no bypass, and after the edge `trap_valid` = 1, `trap_rd` = 3, `trap_data` = 0x80000000, `trap_count` = 1.
  - With `ovf_chk` = 0 and `ovf` = 1, the write commits normally.
- First-fault hold and ack race:
  - While PEND, fault `wa` = 9 with no ack -> `trap_rd` stays 3, `trap_count` = 2.
  - Then `trap_ack` alone -> `trap_valid` = 0 next cycle.
  - Then `trap_ack` together with a fault on `wa` = 4 from PEND -> `trap_valid` stays 1, `trap_rd` = 4.
- Saturation and async reset:
  - 300 consecutive suppressed writes -> `trap_count` = 255.
  - Pulse `rst` mid-cycle while `trap_valid` = 1 -> all outputs are 0 without waiting for a clock edge.

Source files
------------

// File: rtl/reg_file.sv
// reg_file: architectural register file with two combinational read ports, one
// clocked write port, optional same-cycle write-to-read bypass, and an overflow
// trap holding register acknowledged by the control unit.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   ra1/rd1, ra2/rd2    read address / read data (ALU operands a, b)
//   we, wa, wd          write request, address, data (ALU result)
//   ovf_chk, ovf        write is a trapping signed add/sub; ALU overflow flag
//   trap_valid          suppressed-overflow write pending
//   trap_rd, trap_data  destination and wrapped result of the captured fault
//   trap_ack            control unit consumes the pending trap
//   trap_count          saturating count of suppressed writes since reset
module reg_file #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic          ovf_chk,
  input  logic          ovf,
  output logic          trap_valid,
  output logic [AW-1:0] trap_rd,
  output logic [DW-1:0] trap_data,
  input  logic          trap_ack,
  output logic [7:0]    trap_count
);

  localparam int NREG = 2 ** AW;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } trap_state_t;

  logic [DW-1:0] regs [NREG];
  logic          suppress;
  logic          commit;
  logic          fwd_en;
  trap_state_t   state;
  trap_state_t   state_nxt;
  logic          capture;

  // A faulting write is suppressed for any destination, including r0.
  assign suppress = we & ovf_chk & ovf;
  assign commit   = we & ~(ovf_chk & ovf) & (wa != '0);
  // Forwarding is held off during reset so reads stay at zero.
  assign fwd_en   = BYPASS & commit & ~rst;

  // Combinational read ports; r0 reads as zero regardless of array content.
  always_comb begin
    rd1 = regs[ra1];
    if (fwd_en && (wa == ra1)) rd1 = wd;
    if (ra1 == '0) rd1 = '0;
  end

  always_comb begin
    rd2 = regs[ra2];
    if (fwd_en && (wa == ra2)) rd2 = wd;
    if (ra2 == '0) rd2 = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[wa] <= wd;
    end
  end

  // Trap FSM: the first fault is kept until acknowledged; a fault arriving in
  // the same cycle as the ack replaces the one being consumed.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (suppress) begin
          capture   = 1'b1;
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (trap_ack) begin
          if (suppress) capture = 1'b1;
          else          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_rd   <= '0;
      trap_data <= '0;
    end else if (capture) begin
      trap_rd   <= wa;
      trap_data <= wd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trap_count <= '0;
    end else if (suppress && (trap_count != 8'hFF)) begin
      trap_count <= trap_count + 8'd1;
    end
  end

  assign trap_valid = (state == PEND);

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: stimulus pushes expected values into a
// scoreboard queue; a monitor pops and compares on each falling clock edge.
// A second instance with BYPASS = 0 shares all inputs.
module tb_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef enum int { S_RD1, S_RD2, S_RD1B, S_RD2B, S_TV, S_TRD, S_TDATA, S_TCNT } sig_t;

  typedef struct {
    string       name;
    sig_t        sig;
    logic [31:0] exp;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ra1, ra2, wa;
  logic [DW-1:0] wd;
  logic          we, ovf_chk, ovf, trap_ack;

  logic [DW-1:0] rd1, rd2, trap_data;
  logic          trap_valid;
  logic [AW-1:0] trap_rd;
  logic [7:0]    trap_count;

  logic [DW-1:0] rd1_b, rd2_b, trap_data_b;
  logic          trap_valid_b;
  logic [AW-1:0] trap_rd_b;
  logic [7:0]    trap_count_b;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  reg_file #(.DW(DW), .AW(AW), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd), .ovf_chk(ovf_chk), .ovf(ovf),
    .trap_valid(trap_valid), .trap_rd(trap_rd), .trap_data(trap_data),
    .trap_ack(trap_ack), .trap_count(trap_count)
  );

  reg_file #(.DW(DW), .AW(AW), .BYPASS(1'b0)) dut_nobyp (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
    .we(we), .wa(wa), .wd(wd), .ovf_chk(ovf_chk), .ovf(ovf),
    .trap_valid(trap_valid_b), .trap_rd(trap_rd_b), .trap_data(trap_data_b),
    .trap_ack(trap_ack), .trap_count(trap_count_b)
  );

  task automatic expect_val(input sig_t s, input logic [31:0] v, input string nm);
    exp_t e;
    e.name = nm;
    e.sig  = s;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    we = 1'b0; wa = '0; wd = '0; ovf_chk = 1'b0; ovf = 1'b0; trap_ack = 1'b0;
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = sb_q.pop_front();
      case (e.sig)
        S_RD1:   act = rd1;
        S_RD2:   act = rd2;
        S_RD1B:  act = rd1_b;
        S_RD2B:  act = rd2_b;
        S_TV:    act = {31'd0, trap_valid};
        S_TRD:   act = {27'd0, trap_rd};
        S_TDATA: act = trap_data;
        default: act = {24'd0, trap_count};
      endcase
      n_chk++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ra1 = '0; ra2 = '0;
    idle_in();

    // Reset: every address reads zero on both ports of both instances.
    for (int a = 0; a < 32; a++) begin
      cyc();
      ra1 = a[AW-1:0];
      ra2 = 5'(31 - a);
      expect_val(S_RD1,  32'h0, "reset_rd1");
      expect_val(S_RD2,  32'h0, "reset_rd2");
      expect_val(S_RD1B, 32'h0, "reset_rd1_nobyp");
      expect_val(S_RD2B, 32'h0, "reset_rd2_nobyp");
    end
    expect_val(S_TV,    32'h0, "reset_trap_valid");
    expect_val(S_TRD,   32'h0, "reset_trap_rd");
    expect_val(S_TDATA, 32'h0, "reset_trap_data");
    expect_val(S_TCNT,  32'h0, "reset_trap_count");

    // Bypass held off during reset; this write is lost.
    cyc();
    we = 1'b1; wa = 5'd7; wd = 32'hA5A5_A5A5; ra1 = 5'd7;
    expect_val(S_RD1, 32'h0, "reset_no_bypass");

    cyc();
    rst = 1'b0; idle_in(); ra1 = 5'd7; ra2 = 5'd0;
    expect_val(S_RD1, 32'h0, "reset_write_lost");

    cyc();
    we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF; ra1 = 5'd1; ra2 = 5'd2;

    cyc();
    we = 1'b1; wa = 5'd0; wd = 32'h1234_5678; ra1 = 5'd5; ra2 = 5'd0;
    expect_val(S_RD1,  32'hDEAD_BEEF, "r5_read");
    expect_val(S_RD1B, 32'hDEAD_BEEF, "r5_read_nobyp");
    expect_val(S_RD2,  32'h0,         "r0_write_no_bypass");

    cyc();
    we = 1'b1; wa = 5'd7; wd = 32'h0BAD_F00D; ra2 = 5'd0;
    expect_val(S_RD2, 32'h0, "r0_stays_zero");

    cyc();
    we = 1'b1; wa = 5'd7; wd = 32'hA5A5_A5A5; ra1 = 5'd7; ra2 = 5'd7;
    expect_val(S_RD1,  32'hA5A5_A5A5, "bypass_rd1");
    expect_val(S_RD2,  32'hA5A5_A5A5, "bypass_rd2");
    expect_val(S_RD1B, 32'h0BAD_F00D, "nobyp_rd1_old");
    expect_val(S_RD2B, 32'h0BAD_F00D, "nobyp_rd2_old");

    cyc();
    we = 1'b1; wa = 5'd3; wd = 32'h1111_1111; ra1 = 5'd7;
    expect_val(S_RD1,  32'hA5A5_A5A5, "r7_committed");
    expect_val(S_RD1B, 32'hA5A5_A5A5, "r7_committed_nobyp");

    // Overflow fault on r3: no commit, no forwarding.
    cyc();
    we = 1'b1; wa = 5'd3; wd = 32'h8000_0000; ovf_chk = 1'b1; ovf = 1'b1;
    ra1 = 5'd3; ra2 = 5'd3;
    expect_val(S_RD1,  32'h1111_1111, "ovf_no_bypass");
    expect_val(S_RD2B, 32'h1111_1111, "ovf_nobyp_old");
    expect_val(S_TV,   32'h0,         "ovf_tv_before_edge");

    cyc();
    idle_in(); ra1 = 5'd3;
    expect_val(S_RD1,   32'h1111_1111, "ovf_r3_kept");
    expect_val(S_TV,    32'h1,         "ovf_trap_valid");
    expect_val(S_TRD,   32'h3,         "ovf_trap_rd");
    expect_val(S_TDATA, 32'h8000_0000, "ovf_trap_data");
    expect_val(S_TCNT,  32'h1,         "ovf_trap_count");

    // ovf without ovf_chk commits normally.
    cyc();
    we = 1'b1; wa = 5'd10; wd = 32'h7FFF_FFFF; ovf = 1'b1; ra1 = 5'd10;
    expect_val(S_RD1, 32'h7FFF_FFFF, "unchecked_ovf_bypass");
    expect_val(S_TV,  32'h1,         "trap_still_pending");

    // Second fault while pending, no ack: first fault kept.
    cyc();
    we = 1'b1; wa = 5'd9; wd = 32'hCAFE_BABE; ovf_chk = 1'b1; ovf = 1'b1;
    ra1 = 5'd10; ra2 = 5'd9;
    expect_val(S_RD1,  32'h7FFF_FFFF, "unchecked_ovf_commit");
    expect_val(S_RD1B, 32'h7FFF_FFFF, "unchecked_ovf_commit_nobyp");
    expect_val(S_RD2,  32'h0,         "fault2_no_bypass");

    cyc();
    idle_in(); ra2 = 5'd9;
    expect_val(S_RD2,   32'h0,         "fault2_r9_unwritten");
    expect_val(S_TV,    32'h1,         "fault2_tv");
    expect_val(S_TRD,   32'h3,         "first_fault_rd_held");
    expect_val(S_TDATA, 32'h8000_0000, "first_fault_data_held");
    expect_val(S_TCNT,  32'h2,         "fault2_count");

    cyc();
    trap_ack = 1'b1;
    expect_val(S_TV, 32'h1, "ack_tv_before_edge");

    // Now idle; an ack here must be ignored.
    cyc();
    trap_ack = 1'b1;
    expect_val(S_TV,    32'h0,         "ack_tv_clear");
    expect_val(S_TRD,   32'h3,         "ack_rd_hold");
    expect_val(S_TDATA, 32'h8000_0000, "ack_data_hold");

    cyc();
    idle_in();
    expect_val(S_TV,   32'h0, "idle_ack_ignored");
    expect_val(S_TCNT, 32'h2, "idle_ack_count");

    // Fault on r0 is still suppressed and trapped.
    cyc();
    we = 1'b1; wa = 5'd0; wd = 32'h0000_0001; ovf_chk = 1'b1; ovf = 1'b1; ra1 = 5'd0;
    expect_val(S_RD1, 32'h0, "r0_fault_read");

    cyc();
    we = 1'b1; wa = 5'd4; wd = 32'h4444_4444; ovf_chk = 1'b1; ovf = 1'b1;
    trap_ack = 1'b1; ra1 = 5'd4;
    expect_val(S_TV,    32'h1,         "r0_fault_tv");
    expect_val(S_TRD,   32'h0,         "r0_fault_rd");
    expect_val(S_TDATA, 32'h0000_0001, "r0_fault_data");
    expect_val(S_TCNT,  32'h3,         "r0_fault_count");
    expect_val(S_RD1,   32'h0,         "race_no_bypass");

    cyc();
    idle_in(); ra1 = 5'd4;
    expect_val(S_TV,    32'h1,         "race_tv_stays");
    expect_val(S_TRD,   32'h4,         "race_recapture_rd");
    expect_val(S_TDATA, 32'h4444_4444, "race_recapture_data");
    expect_val(S_TCNT,  32'h4,         "race_count");
    expect_val(S_RD1,   32'h0,         "race_r4_unwritten");

    // Saturation: 300 more suppressed writes from a count of 4.
    for (int i = 0; i < 300; i++) begin
      cyc();
      we = 1'b1; wa = 5'(i); wd = 32'(i); ovf_chk = 1'b1; ovf = 1'b1;
    end
    cyc();
    idle_in(); ra1 = 5'd5; ra2 = 5'd7;
    expect_val(S_TCNT, 32'hFF, "count_saturated");
    expect_val(S_TV,   32'h1,  "sat_tv");
    expect_val(S_TRD,  32'h4,  "sat_first_fault_held");
    expect_val(S_RD1,  32'hDEAD_BEEF, "sat_r5_intact");

    // Asynchronous reset mid-cycle: checked before any further rising edge.
    cyc();
    rst = 1'b1; we = 1'b1; wa = 5'd7; wd = 32'hFFFF_FFFF;
    expect_val(S_TV,    32'h0, "arst_trap_valid");
    expect_val(S_TRD,   32'h0, "arst_trap_rd");
    expect_val(S_TDATA, 32'h0, "arst_trap_data");
    expect_val(S_TCNT,  32'h0, "arst_trap_count");
    expect_val(S_RD1,   32'h0, "arst_rd1");
    expect_val(S_RD2,   32'h0, "arst_rd2");
    expect_val(S_RD1B,  32'h0, "arst_rd1_nobyp");

    cyc();
    rst = 1'b0; idle_in(); ra1 = 5'd5; ra2 = 5'd7;
    expect_val(S_RD1, 32'h0, "post_arst_r5");
    expect_val(S_RD2, 32'h0, "post_arst_r7");
    expect_val(S_TV,  32'h0, "post_arst_tv");

    // Drain the scoreboard within a bounded number of cycles.
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
    if (sb_q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
